// File: rtl/sramlike_if.sv
// sram-like bus (req/addr_ok/data_ok) between an arbiter or CPU port (master)
// and a cache or AXI bridge (slave).
interface sramlike_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sramlike_arbiter.sv
// NCH-channel sram-like arbiter with an in-order response router (order FIFO).
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority, channel 0 highest.
module sramlike_arbiter #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [2*NCH-1:0]  ch_size,
  input  logic [AW*NCH-1:0] ch_addr,
  input  logic [DW*NCH-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_addr_ok,
  output logic [NCH-1:0]    ch_data_ok,
  output logic [DW-1:0]     ch_rdata,
  sramlike_if.master        m,
  output logic              err
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
    logic [NCH-1:0] v;
    v = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      v[i] = (IW'(i) == idx);
    end
    return v;
  endfunction

  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IW-1:0]  fifo_q [DEPTH];
  logic [IW-1:0]  fifo_d [DEPTH];
  logic           lock_q, lock_d;
  logic [IW-1:0]  lock_id_q, lock_id_d;
  logic           err_q, err_d;
`ifdef RR_ARB_EN
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  cand_s;
`endif

  logic           full_s;
  logic [NCH-1:0] elig_s;
  logic [IW-1:0]  grant_s;
  logic           gvalid_s;
  logic           push_s;
  logic           pop_s;
  logic [IW-1:0]  head_s;

  // Grant selection: a stalled request keeps its channel until accepted.
  always_comb begin
    full_s   = (count_q == CW'(DEPTH));
    elig_s   = full_s ? {NCH{1'b0}} : ch_req;
    grant_s  = {IW{1'b0}};
    gvalid_s = 1'b0;
`ifdef RR_ARB_EN
    cand_s   = {IW{1'b0}};
`endif
    if (lock_q) begin
      grant_s  = lock_id_q;
      gvalid_s = ch_req[lock_id_q];
    end else begin
`ifdef RR_ARB_EN
      for (int i = 0; i < NCH; i++) begin
        cand_s = IW'((int'(rr_q) + i + 32'sd1) % NCH);
        if (!gvalid_s && elig_s[cand_s]) begin
          grant_s  = cand_s;
          gvalid_s = 1'b1;
        end else begin
          gvalid_s = gvalid_s;
        end
      end
`else
      for (int i = NCH - 1; i >= 0; i--) begin
        if (elig_s[i]) begin
          grant_s  = IW'(i);
          gvalid_s = 1'b1;
        end else begin
          gvalid_s = gvalid_s;
        end
      end
`endif
    end
  end

  // Master port mux and zero-latency handshake/response routing.
  always_comb begin
    m.req      = gvalid_s;
    m.wr       = gvalid_s & ch_wr[grant_s];
    m.size     = gvalid_s ? ch_size[int'(grant_s)*2 +: 2] : 2'b00;
    m.addr     = gvalid_s ? ch_addr[int'(grant_s)*AW +: AW] : {AW{1'b0}};
    m.wdata    = gvalid_s ? ch_wdata[int'(grant_s)*DW +: DW] : {DW{1'b0}};
    push_s     = gvalid_s & m.addr_ok;
    pop_s      = m.data_ok & (count_q != {CW{1'b0}});
    head_s     = fifo_q[rptr_q];
    ch_addr_ok = push_s ? onehot(grant_s) : {NCH{1'b0}};
    ch_data_ok = pop_s ? onehot(head_s) : {NCH{1'b0}};
    ch_rdata   = pop_s ? m.rdata : {DW{1'b0}};
    err        = err_q;
  end

  // Next-state: order FIFO, lock tracking, sticky error, rr pointer.
  always_comb begin
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (push_s) begin
      fifo_d[wptr_q] = grant_s;
      wptr_d         = wptr_q + PW'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1'b1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
    if (push_s) begin
      lock_d = 1'b0;
    end else if (gvalid_s) begin
      lock_d    = 1'b1;
      lock_id_d = grant_s;
    end else begin
      // A locked channel that withdrew its request releases the lock.
      lock_d = 1'b0;
    end
    err_d = err_q
          | (m.data_ok & (count_q == {CW{1'b0}}))
          | (lock_q & ~ch_req[lock_id_q]);
`ifdef RR_ARB_EN
    rr_d = push_s ? grant_s : rr_q;
`endif
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= {IW{1'b0}};
      end
      wptr_q    <= {PW{1'b0}};
      rptr_q    <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      lock_q    <= 1'b0;
      lock_id_q <= {IW{1'b0}};
      err_q     <= 1'b0;
`ifdef RR_ARB_EN
      rr_q      <= {IW{1'b0}};
`endif
    end else begin
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
`ifdef RR_ARB_EN
      rr_q      <= rr_d;
`endif
    end
  end
endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed testbench for sramlike_arbiter (NCH=2, DEPTH=4).
module tb_sramlike_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  ch_req, ch_wr;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr, ch_wdata;
  logic [1:0]  ch_addr_ok, ch_data_ok;
  logic [31:0] ch_rdata;
  logic        err;
  int          n_chk = 0;
  int          n_fail = 0;

  sramlike_if #(.AW(32), .DW(32)) mif ();

  sramlike_arbiter #(.NCH(2), .AW(32), .DW(32), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok),
    .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata), .m(mif), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ch_req = 2'b00; ch_wr = 2'b00; mif.addr_ok = 1'b0; mif.data_ok = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    ch_size = 4'b1010; ch_addr = {32'h2000_0000, 32'h1000_0000};
    ch_wdata = {32'h2222_2222, 32'h1111_1111};
    mif.rdata = 32'hDEAD_BEEF;
    #3;
    n_chk++; if (mif.req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %b want 0", mif.req); end
    n_chk++; if (ch_addr_ok !== 2'b00) begin n_fail++; $display("FAIL reset_addr_ok: got %b want 00", ch_addr_ok); end
    n_chk++; if (ch_data_ok !== 2'b00) begin n_fail++; $display("FAIL reset_data_ok: got %b want 00", ch_data_ok); end
    n_chk++; if (ch_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", ch_rdata); end
    n_chk++; if (mif.addr !== 32'h0) begin n_fail++; $display("FAIL reset_m_addr: got %h want 0", mif.addr); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    ch_req = 2'b01; ch_addr[31:0] = 32'hBFC0_0000; mif.addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (ch_addr_ok !== 2'b01) begin n_fail++; $display("FAIL single_addr_ok: got %b want 01", ch_addr_ok); end
    n_chk++; if (mif.addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL single_m_addr: got %h want bfc00000", mif.addr); end
    n_chk++; if (mif.size !== 2'd2) begin n_fail++; $display("FAIL single_m_size: got %0d want 2", mif.size); end
    tick();
    idle(); mif.data_ok = 1'b1; mif.rdata = 32'h3C1D_8000;
    @(negedge clk);
    n_chk++; if (ch_data_ok !== 2'b01) begin n_fail++; $display("FAIL single_data_ok: got %b want 01", ch_data_ok); end
    n_chk++; if (ch_rdata !== 32'h3C1D_8000) begin n_fail++; $display("FAIL single_rdata: got %h want 3c1d8000", ch_rdata); end
    tick();
    idle();
  endtask

  task automatic test_lock();
    ch_addr = {32'hA000_0010, 32'hB000_0020};
    ch_req = 2'b10; mif.addr_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) ch_req = 2'b11;
      @(negedge clk);
      n_chk++; if (mif.addr !== 32'hA000_0010) begin n_fail++; $display("FAIL lock_m_addr c%0d: got %h want a0000010", c, mif.addr); end
      n_chk++; if (ch_addr_ok !== 2'b00) begin n_fail++; $display("FAIL lock_stall c%0d: got %b want 00", c, ch_addr_ok); end
      tick();
    end
    mif.addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (ch_addr_ok !== 2'b10) begin n_fail++; $display("FAIL lock_accept: got %b want 10", ch_addr_ok); end
    tick();
    idle(); mif.data_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (ch_data_ok !== 2'b10) begin n_fail++; $display("FAIL lock_resp: got %b want 10", ch_data_ok); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    ch_req = 2'b10; ch_wr = 2'b10; mif.addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (ch_addr_ok !== 2'b10) begin n_fail++; $display("FAIL b2b_acc1: got %b want 10", ch_addr_ok); end
    n_chk++; if (mif.wr !== 1'b1 || mif.wdata !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_write: got wr=%b wdata=%h want 1 22222222", mif.wr, mif.wdata); end
    tick();
    ch_req = 2'b01; ch_wr = 2'b00;
    @(negedge clk);
    n_chk++; if (ch_addr_ok !== 2'b01 || mif.wr !== 1'b0) begin n_fail++; $display("FAIL b2b_acc0: got %b wr=%b want 01 wr=0", ch_addr_ok, mif.wr); end
    tick();
    idle(); mif.data_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (ch_data_ok !== 2'b10) begin n_fail++; $display("FAIL b2b_resp1: got %b want 10", ch_data_ok); end
    tick();
    @(negedge clk);
    n_chk++; if (ch_data_ok !== 2'b01) begin n_fail++; $display("FAIL b2b_resp2: got %b want 01", ch_data_ok); end
    tick();
    idle();
  endtask

  task automatic test_full();
    ch_req = 2'b01; mif.addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++; if (ch_addr_ok !== 2'b01) begin n_fail++; $display("FAIL full_fill%0d: got %b want 01", c, ch_addr_ok); end
      tick();
    end
    @(negedge clk);
    n_chk++; if (mif.req !== 1'b0 || ch_addr_ok !== 2'b00) begin n_fail++; $display("FAIL full_mask: got req=%b ok=%b want 0 00", mif.req, ch_addr_ok); end
    tick();
    mif.data_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (mif.req !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle: got req=%b want 0", mif.req); end
    n_chk++; if (ch_data_ok !== 2'b01) begin n_fail++; $display("FAIL full_pop: got %b want 01", ch_data_ok); end
    tick();
    mif.data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (mif.req !== 1'b1 || ch_addr_ok !== 2'b01) begin n_fail++; $display("FAIL full_unmask: got req=%b ok=%b want 1 01", mif.req, ch_addr_ok); end
    tick();
    idle(); mif.data_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++; if (ch_data_ok !== 2'b01) begin n_fail++; $display("FAIL full_drain%0d: got %b want 01", c, ch_data_ok); end
      tick();
    end
    idle();
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_ok [4];
    logic [1:0] prev;
`ifdef RR_ARB_EN
    exp_ok = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_ok = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    ch_req = 2'b10; mif.addr_ok = 1'b1;
    tick();
    prev = 2'b10;
    ch_req = 2'b11; mif.data_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++; if (ch_addr_ok !== exp_ok[c]) begin n_fail++; $display("FAIL arb_grant%0d: got %b want %b", c, ch_addr_ok, exp_ok[c]); end
      n_chk++; if (ch_data_ok !== prev) begin n_fail++; $display("FAIL arb_resp%0d: got %b want %b", c, ch_data_ok, prev); end
      prev = exp_ok[c];
      tick();
    end
    ch_req = 2'b00; mif.addr_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (ch_data_ok !== prev) begin n_fail++; $display("FAIL arb_drain: got %b want %b", ch_data_ok, prev); end
    tick();
    idle();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL pre_err_clean: got %b want 0", err); end
  endtask

  task automatic test_errors();
    ch_req = 2'b10; mif.addr_ok = 1'b0;
    tick();
    ch_req = 2'b00;
    @(negedge clk);
    n_chk++; if (mif.req !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL lockdrop_pre: got req=%b err=%b want 0 0", mif.req, err); end
    tick();
    @(negedge clk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL lockdrop_err: got %b want 1", err); end
    tick();
    do_reset();
    @(negedge clk);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err); end
    tick();
    mif.data_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (ch_data_ok !== 2'b00) begin n_fail++; $display("FAIL empty_resp_drop: got %b want 00", ch_data_ok); end
    tick();
    mif.data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL empty_resp_err: got %b want 1", err); end
    tick();
    ch_req = 2'b01; mif.addr_ok = 1'b1;
    tick();
    ch_req = 2'b10;
    tick();
    idle();
    resetn = 1'b0;
    #2;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got %b want 0", err); end
    tick();
    resetn = 1'b1;
    mif.data_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (ch_data_ok !== 2'b00) begin n_fail++; $display("FAIL stale_resp_drop: got %b want 00", ch_data_ok); end
    tick();
    mif.data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL stale_resp_err: got %b want 1", err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_lock();
    test_back_to_back();
    test_full();
    test_arbitration();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sramlike_arbiter.md
# sramlike_arbiter

Parametrised N-channel arbiter and response router for the sram-like bus (req/addr_ok/data_ok) that replaces the fixed single-cycle SRAM ports at the CPU top. It merges NCH upstream requesters, typically instruction fetch and data access, onto one sram-like master port toward the cache/AXI bridge. It tracks up to DEPTH outstanding transactions in an order FIFO so each data_ok is routed back to the channel that issued it. It adds zero cycles to the handshake path.

## Interface
- NCH, 2: number of upstream channels (2..8); channel 0 is highest fixed priority.
- AW, 32: address width.
- DW, 32: data width.
- DEPTH, 4: maximum outstanding transactions; power of two, 2..16.
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- ch_req  in  NCH  per-channel request.
- ch_wr  in  NCH  per-channel write (1) / read (0).
- ch_size  in  2*NCH  per-channel size: 0 byte, 1 half, 2 word; channel k at [2k+1:2k].
- ch_addr  in  AW*NCH  per-channel address (physical, post-MMU).
- ch_wdata  in  DW*NCH  per-channel write data.
- ch_addr_ok  out  NCH  request accepted, one-hot or zero.
- ch_data_ok  out  NCH  response returned, one-hot or zero.
- ch_rdata  out  DW  read data, broadcast; valid with ch_data_ok.
- m_req, m_wr  out  1  master request / write.
- m_size  out  2  master size.
- m_addr  out  AW  master address.
- m_wdata  out  DW  master write data.
- m_addr_ok  in  1  slave accepted request.
- m_data_ok  in  1  slave returns response; in-order.
- m_rdata  in  DW  slave read data.
- err  out  1  sticky protocol error.

## Operation
- Eligible request set: ch_req, masked to zero when the order FIFO is full.
- Grant:
  - Locked: the grant is lock_id.
  - Unlocked: the grant is picked from the eligible set by the arbitration policy (see Configuration).
  - Without a grant, m_req=0.
- m_req/m_wr/m_size/m_addr/m_wdata are muxed combinationally from the granted channel. When m_req=0, m_addr, m_wdata and m_size are 0.
- Handshake: m_req & m_addr_ok at the edge.
  - ch_addr_ok[grant]=1 in the same cycle.
  - The grant index is pushed into the order FIFO.
  - The lock clears.
- Lock: m_req & ~m_addr_ok at the edge sets lock=1 and lock_id=grant. The grant is then held until acceptance, even if a higher-priority channel raises req.
  - Locked channel drops ch_req before acceptance: err is set and the lock clears next edge.
- Response: m_data_ok with the FIFO non-empty:
  - ch_data_ok[head]=1 and ch_rdata=m_rdata in the same cycle.
  - The FIFO pops.
- Response with the FIFO empty: dropped (no ch_data_ok) and err is set.
- Simultaneous push and pop: both happen; occupancy is unchanged. Full masking uses the registered count only; a same-cycle pop does not unmask.
- Occupancy counter is 0..DEPTH, $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- err is sticky and clears only on reset.

## Timing
- Reset (async assert, sync release):
  - FIFO empty, count=0, lock=0, lock_id=0, rr pointer=0, err=0.
  - All ch_addr_ok, ch_data_ok and m_req are 0 and ch_rdata=0 (combinational from reset state plus inputs).
- Added latency: 0 cycles. addr_ok and data_ok are pure combinational passes.
- The earliest ch_data_ok for a request accepted at edge t is the cycle after t.
- A request and a response for different channels may complete in the same cycle.
- Reset mid-operation discards the outstanding order. Later m_data_ok pulses for pre-reset requests are dropped and set err.

## Configuration
- RR_ARB_EN defined: round-robin arbitration.
  - The pointer records the last accepted channel.
  - The search starts at pointer+1 modulo NCH.
  - The pointer updates only on a handshake.
- RR_ARB_EN undefined: fixed priority; the lowest eligible index wins. No pointer register.

## Test plan
- Single read, NCH=2: ch_req=01, addr 0xBFC00000, m_addr_ok=1 same cycle, m_data_ok next cycle with m_rdata=0x3C1D8000 -> ch_addr_ok=01 in cycle 0; ch_data_ok=01 and ch_rdata=0x3C1D8000 in cycle 1.
- Lock: ch_req=10, m_addr_ok held 0 for 3 cycles, ch_req becomes 11 in cycle 1 -> m_addr stays channel 1's address for all 3 cycles; ch_addr_ok=10 on acceptance.
- Ordering: ch1 write then ch0 read accepted back to back, responses in the next 2 cycles -> ch_data_ok=10 then 01.
- Full, DEPTH=4: 4 accepts with no m_data_ok -> m_req=0 on the 5th request. One m_data_ok -> m_req=1 the following cycle. Count never exceeds 4.
- Round-robin (RR_ARB_EN): ch_req=11 continuously, m_addr_ok=1, m_data_ok=1 -> acceptances alternate 01,10,01,10. Without the macro -> 01 every cycle.
- Errors: m_data_ok with the FIFO empty -> err=1, no ch_data_ok. resetn pulse low mid-stream with 2 outstanding -> err=0, count=0; the next m_data_ok sets err.
